// File: rtl/ex_stage_pkg.sv
// ----------------------------------------------------------------------------
// ex_stage_pkg
// Shared definitions for the execute stage of the 8-bit pipelined core:
//   - datapath / register-index widths
//   - ALU operation encoding (alu_op_e)
//   - execute-stage FSM state encoding (state_e)
//   - fwd_operand(): EX/WB -> EX operand forwarding selection
// ----------------------------------------------------------------------------
package ex_stage_pkg;

  localparam int DATA_W = 8;
  localparam int REG_W  = 3;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SHL = 3'b101,
    ALU_SHR = 3'b110,
    ALU_MUL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Forward the EX/WB value when it writes the register being read.
  // Register index 0 is an ordinary register, so it forwards too.
  function automatic logic [DATA_W-1:0] fwd_operand(
    input logic              fwd_we,
    input logic [REG_W-1:0]  fwd_rd,
    input logic [REG_W-1:0]  src_idx,
    input logic [DATA_W-1:0] fwd_val,
    input logic [DATA_W-1:0] rf_val
  );
    logic [DATA_W-1:0] sel;
    if (fwd_we && (fwd_rd == src_idx)) begin
      sel = fwd_val;
    end else begin
      sel = rf_val;
    end
    return sel;
  endfunction

endpackage : ex_stage_pkg

// File: rtl/ex_stage_mul8_seq.sv
// ----------------------------------------------------------------------------
// mul8_seq
// Iterative 8x8 shift-add multiplier producing the low 8 bits of the product.
// A start pulse loads the operands and clears the accumulator; the following
// 8 cycles each perform one shift-add step. done_o is high during the last
// step, and product_o (the accumulator) is final on the cycle after it.
//
// Ports:
//   clk_i      in   rising-edge clock
//   rst_i      in   synchronous active-high reset, clears all state
//   start_i    in   load operands and begin a multiply
//   mcand_i    in   [8] multiplicand
//   mplier_i   in   [8] multiplier
//   busy_o     out  a shift-add step happens this cycle
//   done_o     out  this cycle is the final (8th) step
//   product_o  out  [8] accumulator, modulo-256 product once finished
// ----------------------------------------------------------------------------
module mul8_seq
  import ex_stage_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] mcand_i,
  input  logic [DATA_W-1:0] mplier_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  logic [DATA_W-1:0] acc_q,    acc_d;
  logic [DATA_W-1:0] mcand_q,  mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [2:0]        cnt_q,    cnt_d;
  logic              busy_q,   busy_d;

  // Next-state for operand load and one shift-add step per busy cycle.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start_i) begin
      acc_d    = '0;
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      cnt_d    = 3'd0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end else begin
        acc_d = acc_q;
      end
      mcand_d  = {mcand_q[DATA_W-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[DATA_W-1:1]};
      cnt_d    = cnt_q + 3'd1;
      busy_d   = (cnt_q != 3'd7);
    end else begin
      busy_d = 1'b0;
    end
  end

  // Multiplier state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= 3'd0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == 3'd7);
  assign product_o = acc_q;

endmodule : mul8_seq

// File: rtl/ex_stage.sv
// ----------------------------------------------------------------------------
// ex_stage
// Execute stage between ID/EX and EX/WB. Resolves operand forwarding from
// EX/WB, computes single-cycle ALU results combinationally, and sequences a
// 10-cycle iterative multiply (issue, 8 steps, done) while stalling upstream.
//
// Ports:
//   clk_i                in   rising-edge clock
//   reset_i              in   synchronous active-high reset (forces outputs 0)
//   valid_id_ex_i        in   ID/EX holds a real instruction (0 = bubble)
//   regwrite_id_ex_i     in   instruction writes the register file
//   aluop_id_ex_i        in   [3] operation select (alu_op_e)
//   rs_id_ex_i           in   [3] source A register index
//   rt_id_ex_i           in   [3] source B register index
//   rd_id_ex_i           in   [3] destination register index
//   readdata1_id_ex_i    in   [8] register file operand A
//   readdata2_id_ex_i    in   [8] register file operand B
//   regwrite_ex_wb_i     in   forwarding source write-enable
//   rd_ex_wb_i           in   [3] forwarding source destination
//   aluresult_ex_wb_i    in   [8] forwarding source value
//   aluresult_o          out  [8] result to EX/WB
//   regwrite_ex_o        out  qualified write-enable to EX/WB
//   rd_ex_o              out  [3] destination to EX/WB
//   stall_o              out  hold PC, IF/ID and ID/EX
// ----------------------------------------------------------------------------
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              valid_id_ex_i,
  input  logic              regwrite_id_ex_i,
  input  logic [2:0]        aluop_id_ex_i,
  input  logic [REG_W-1:0]  rs_id_ex_i,
  input  logic [REG_W-1:0]  rt_id_ex_i,
  input  logic [REG_W-1:0]  rd_id_ex_i,
  input  logic [DATA_W-1:0] readdata1_id_ex_i,
  input  logic [DATA_W-1:0] readdata2_id_ex_i,
  input  logic              regwrite_ex_wb_i,
  input  logic [REG_W-1:0]  rd_ex_wb_i,
  input  logic [DATA_W-1:0] aluresult_ex_wb_i,
  output logic [DATA_W-1:0] aluresult_o,
  output logic              regwrite_ex_o,
  output logic [REG_W-1:0]  rd_ex_o,
  output logic              stall_o
);

  state_e            state_q, state_d;
  logic [REG_W-1:0]  rd_lat_q, rd_lat_d;
  logic              we_lat_q, we_lat_d;

  alu_op_e           op_s;
  logic [DATA_W-1:0] opa_s;
  logic [DATA_W-1:0] opb_s;
  logic [DATA_W-1:0] alu_res_s;
  logic              is_mul_s;
  logic              mul_start_s;
  logic              mul_busy_s;
  logic              mul_done_s;
  logic [DATA_W-1:0] mul_prod_s;

  assign op_s  = alu_op_e'(aluop_id_ex_i);
  assign opa_s = fwd_operand(regwrite_ex_wb_i, rd_ex_wb_i, rs_id_ex_i,
                             aluresult_ex_wb_i, readdata1_id_ex_i);
  assign opb_s = fwd_operand(regwrite_ex_wb_i, rd_ex_wb_i, rt_id_ex_i,
                             aluresult_ex_wb_i, readdata2_id_ex_i);

  assign is_mul_s    = valid_id_ex_i && (op_s == ALU_MUL);
  // Reset wins inside the multiplier, so start need not be qualified by it.
  assign mul_start_s = (state_q == ST_IDLE) && is_mul_s;

  mul8_seq u_mul (
    .clk_i     (clk_i),
    .rst_i     (reset_i),
    .start_i   (mul_start_s),
    .mcand_i   (opa_s),
    .mplier_i  (opb_s),
    .busy_o    (mul_busy_s),
    .done_o    (mul_done_s),
    .product_o (mul_prod_s)
  );

  // Single-cycle ALU; results wrap modulo 256.
  always_comb begin
    alu_res_s = '0;
    case (op_s)
      ALU_ADD: alu_res_s = opa_s + opb_s;
      ALU_SUB: alu_res_s = opa_s - opb_s;
      ALU_AND: alu_res_s = opa_s & opb_s;
      ALU_OR:  alu_res_s = opa_s | opb_s;
      ALU_XOR: alu_res_s = opa_s ^ opb_s;
      ALU_SHL: alu_res_s = {opa_s[DATA_W-2:0], 1'b0};
      ALU_SHR: alu_res_s = {1'b0, opa_s[DATA_W-1:1]};
      default: alu_res_s = '0;
    endcase
  end

  // FSM next state and latching of the multiply's destination at issue.
  always_comb begin
    state_d  = state_q;
    rd_lat_d = rd_lat_q;
    we_lat_d = we_lat_q;
    case (state_q)
      ST_IDLE: begin
        if (is_mul_s) begin
          state_d  = ST_MUL;
          rd_lat_d = rd_id_ex_i;
          we_lat_d = regwrite_id_ex_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mul_busy_s && mul_done_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_MUL;
        end
      end
      // Always return to IDLE so a MUL still held in ID/EX is not reissued
      // from DONE; it issues fresh from IDLE on the following cycle.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and latched destination registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      rd_lat_q <= '0;
      we_lat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_lat_q <= rd_lat_d;
      we_lat_q <= we_lat_d;
    end
  end

  // Output qualification; stall depends only on state, valid, op and reset.
  always_comb begin
    aluresult_o   = '0;
    regwrite_ex_o = 1'b0;
    rd_ex_o       = '0;
    stall_o       = 1'b0;
    if (reset_i) begin
      stall_o = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (is_mul_s) begin
            stall_o = 1'b1;
          end else if (valid_id_ex_i) begin
            aluresult_o   = alu_res_s;
            regwrite_ex_o = regwrite_id_ex_i;
            rd_ex_o       = rd_id_ex_i;
          end else begin
            stall_o = 1'b0;
          end
        end
        ST_MUL:  stall_o = 1'b1;
        ST_DONE: begin
          aluresult_o   = mul_prod_s;
          regwrite_ex_o = we_lat_q;
          rd_ex_o       = rd_lat_q;
        end
        default: stall_o = 1'b0;
      endcase
    end
  end

endmodule : ex_stage
